// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter in front of one single-port SRAM macro: round-robin
// grant with optional burst lock, combinational macro drive, tagged read return.
module sram_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_i,
  input  logic [1:0]                 we_i,
  input  logic [1:0][DATA_W/8-1:0]   be_i,
  input  logic [1:0][ADDR_W-1:0]     addr_i,
  input  logic [1:0][DATA_W-1:0]     wdata_i,
  input  logic [1:0]                 lock_i,
  output logic [1:0]                 gnt_o,
  output logic [1:0]                 rvalid_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       sram_cs_o,
  output logic                       sram_oe_o,
  output logic [DATA_W/8-1:0]        sram_web_o,
  output logic [ADDR_W-1:0]          sram_a_o,
  output logic [DATA_W-1:0]          sram_di_o,
  input  logic [DATA_W-1:0]          sram_di_i
);

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_0    = 2'd1,
    LOCK_1    = 2'd2
  } lock_e;

  logic       rr_ptr_q, rr_ptr_d;
  lock_e      lock_owner_q, lock_owner_d;
  logic [1:0] rd_pend_q, rd_pend_d;

  logic [1:0] gnt;
  logic       gnt_idx;
  logic       locked_cont;

  // Grant selection: lock owner first, then round-robin priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    gnt         = 2'b00;
    locked_cont = 1'b0;
    if (!rst) begin
      if (lock_owner_q == LOCK_0 && req_i[0]) begin
        gnt         = 2'b01;
        locked_cont = 1'b1;
      end else if (lock_owner_q == LOCK_1 && req_i[1]) begin
        gnt         = 2'b10;
        locked_cont = 1'b1;
      end else if (req_i[rr_ptr_q]) begin
        gnt[rr_ptr_q] = 1'b1;
      end else if (req_i[~rr_ptr_q]) begin
        gnt[~rr_ptr_q] = 1'b1;
      end
    end
    gnt_idx = gnt[1];
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if ((|gnt) && !locked_cont) begin
      rr_ptr_d = ~gnt_idx;
    end

    // A live owner that still requests is always granted, so an idle cycle or a
    // grant without lock_i means the lock is released.
    lock_owner_d = LOCK_NONE;
    if ((|gnt) && lock_i[gnt_idx]) begin
      lock_owner_d = gnt_idx ? LOCK_1 : LOCK_0;
    end

    rd_pend_d = gnt & ~we_i;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      rr_ptr_q     <= 1'b0;
      lock_owner_q <= LOCK_NONE;
      rd_pend_q    <= 2'b00;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_owner_q <= lock_owner_d;
      rd_pend_q    <= rd_pend_d;
    end
  end

  // Macro drive follows the granted requester; idle bus is parked at zero.
  always_comb begin
    sram_cs_o  = 1'b0;
    sram_web_o = '1;
    sram_a_o   = '0;
    sram_di_o  = '0;
    if (|gnt) begin
      sram_cs_o  = 1'b1;
      sram_a_o   = addr_i[gnt_idx];
      sram_di_o  = wdata_i[gnt_idx];
      sram_web_o = we_i[gnt_idx] ? ~be_i[gnt_idx] : '1;
    end
  end

  // The pending tag is masked during reset so a read in flight is dropped at once.
  always_comb begin
    rvalid_o = rst ? 2'b00 : rd_pend_q;
    rdata_o  = (|rvalid_o) ? sram_di_i : '0;
  end

  assign gnt_o     = gnt;
  assign sram_oe_o = 1'b1;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural one-cycle-latency SRAM.
module tb_sram_port_arbiter;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int NB     = DATA_W / 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [1:0]               req_i, we_i, lock_i;
  logic [1:0][NB-1:0]       be_i;
  logic [1:0][ADDR_W-1:0]   addr_i;
  logic [1:0][DATA_W-1:0]   wdata_i;
  logic [1:0]               gnt_o, rvalid_o;
  logic [DATA_W-1:0]        rdata_o;
  logic                     sram_cs_o, sram_oe_o;
  logic [NB-1:0]            sram_web_o;
  logic [ADDR_W-1:0]        sram_a_o;
  logic [DATA_W-1:0]        sram_di_o;
  logic [DATA_W-1:0]        sram_do;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .lock_i(lock_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .sram_cs_o(sram_cs_o),
    .sram_oe_o(sram_oe_o), .sram_web_o(sram_web_o), .sram_a_o(sram_a_o),
    .sram_di_o(sram_di_o), .sram_di_i(sram_do)
  );

  // SRAM macro: registered read, per-byte active-low write enables.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (sram_cs_o) begin
      if (&sram_web_o) sram_do <= mem[sram_a_o];
      else begin
        for (int b = 0; b < NB; b++)
          if (!sram_web_o[b]) mem[sram_a_o][8*b +: 8] <= sram_di_o[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the middle of the next cycle; caller then drives and checks.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    req_i  = 2'b00;
    we_i   = 2'b00;
    lock_i = 2'b00;
  endtask

  initial begin
    mem[14'h010] = 32'hDEADBEEF;
    mem[14'h3FF] = 32'hAAAAAAAA;
    mem[14'h001] = 32'h01010101;
    mem[14'h002] = 32'h02020202;
    mem[14'h003] = 32'h03030303;

    // Reset with both requesting: everything held quiet.
    rst = 1'b1; req_i = 2'b11; we_i = 2'b00; lock_i = 2'b11;
    be_i = '1; addr_i = '0; wdata_i = '0;
    settle();
    chk("rst_gnt",    gnt_o, 2'b00);
    chk("rst_cs",     sram_cs_o, 1'b0);
    chk("rst_rvalid", rvalid_o, 2'b00);
    chk("rst_rdata",  rdata_o, 32'h0);
    chk("rst_web",    sram_web_o, 4'hF);
    chk("oe_tied",    sram_oe_o, 1'b1);
    next_cycle();
    next_cycle();

    // Single read by requester 0.
    rst = 1'b0; idle(); req_i = 2'b01; addr_i[0] = 14'h010;
    settle();
    chk("rd0_gnt",  gnt_o, 2'b01);
    chk("rd0_cs",   sram_cs_o, 1'b1);
    chk("rd0_web",  sram_web_o, 4'hF);
    chk("rd0_addr", sram_a_o, 14'h010);
    next_cycle(); idle(); settle();
    chk("rd0_rvalid", rvalid_o, 2'b01);
    chk("rd0_rdata",  rdata_o, 32'hDEADBEEF);
    chk("idle_cs",    sram_cs_o, 1'b0);
    chk("idle_addr",  sram_a_o, 14'h0);

    // Partial-byte write by requester 1, then read back.
    next_cycle();
    req_i = 2'b10; we_i = 2'b10; be_i[1] = 4'b0101;
    addr_i[1] = 14'h3FF; wdata_i[1] = 32'h11223344;
    settle();
    chk("wr1_gnt",  gnt_o, 2'b10);
    chk("wr1_web",  sram_web_o, 4'b1010);
    chk("wr1_di",   sram_di_o, 32'h11223344);
    chk("wr1_addr", sram_a_o, 14'h3FF);
    next_cycle(); we_i = 2'b00; be_i[1] = 4'hF; settle();
    chk("wr1_no_rvalid", rvalid_o, 2'b00);
    chk("rb1_gnt", gnt_o, 2'b10);
    next_cycle(); idle(); settle();
    chk("rb1_rvalid", rvalid_o, 2'b10);
    chk("rb1_rdata",  rdata_o, 32'hAA22AA44);

    // Write with no byte enables: granted, CS high, nothing written.
    next_cycle();
    req_i = 2'b01; we_i = 2'b01; be_i[0] = 4'h0; addr_i[0] = 14'h010; wdata_i[0] = 32'h0;
    settle();
    chk("be0_gnt", gnt_o, 2'b01);
    chk("be0_cs",  sram_cs_o, 1'b1);
    chk("be0_web", sram_web_o, 4'hF);
    next_cycle(); we_i = 2'b00; be_i[0] = 4'hF; req_i = 2'b01; settle();
    chk("be0_no_rvalid", rvalid_o, 2'b00);
    next_cycle(); idle(); settle();
    chk("be0_rdata", rdata_o, 32'hDEADBEEF);

    // Round-robin from reset: both request for 6 cycles.
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0;
    req_i = 2'b11; addr_i[0] = 14'h001; addr_i[1] = 14'h002;
    settle(); chk("rr_c0", gnt_o, 2'b01);
    next_cycle(); settle(); chk("rr_c1", gnt_o, 2'b10);
    chk("rr_c1_rdata", rdata_o, 32'h01010101);
    next_cycle(); settle(); chk("rr_c2", gnt_o, 2'b01);
    chk("rr_c2_rvalid", rvalid_o, 2'b10);
    next_cycle(); settle(); chk("rr_c3", gnt_o, 2'b10);
    next_cycle(); settle(); chk("rr_c4", gnt_o, 2'b01);
    next_cycle(); settle(); chk("rr_c5", gnt_o, 2'b10);

    // Requester 0 alone moves priority to requester 1.
    next_cycle(); req_i = 2'b01; settle();
    chk("pre_lock_gnt", gnt_o, 2'b01);

    // Requester 1 locks for 4 reads while requester 0 keeps asking.
    next_cycle(); req_i = 2'b11; lock_i = 2'b10; settle();
    chk("lock_g1", gnt_o, 2'b10);
    next_cycle(); settle(); chk("lock_g2", gnt_o, 2'b10);
    next_cycle(); settle(); chk("lock_g3", gnt_o, 2'b10);
    next_cycle(); lock_i = 2'b00; settle(); chk("lock_g4", gnt_o, 2'b10);
    next_cycle(); settle(); chk("lock_release", gnt_o, 2'b01);

    // Reset lands in the cycle after a read grant.
    next_cycle(); req_i = 2'b01; addr_i[0] = 14'h010; settle();
    chk("rstrd_gnt", gnt_o, 2'b01);
    next_cycle(); rst = 1'b1; req_i = 2'b11; settle();
    chk("rstrd_rvalid", rvalid_o, 2'b00);
    chk("rstrd_rdata",  rdata_o, 32'h0);
    chk("rstrd_gnt_off", gnt_o, 2'b00);
    chk("rstrd_cs", sram_cs_o, 1'b0);
    next_cycle(); settle();
    chk("rstrd_hold_rvalid", rvalid_o, 2'b00);
    next_cycle(); rst = 1'b0; idle(); settle();
    chk("rstrd_dropped", rvalid_o, 2'b00);

    // Back-to-back reads 0 -> 1 -> 0.
    next_cycle(); req_i = 2'b01; addr_i[0] = 14'h001; settle();
    chk("b2b_g0", gnt_o, 2'b01);
    next_cycle(); req_i = 2'b10; addr_i[1] = 14'h002; settle();
    chk("b2b_g1", gnt_o, 2'b10);
    chk("b2b_v0", rvalid_o, 2'b01);
    chk("b2b_d0", rdata_o, 32'h01010101);
    next_cycle(); req_i = 2'b01; addr_i[0] = 14'h003; settle();
    chk("b2b_g2", gnt_o, 2'b01);
    chk("b2b_v1", rvalid_o, 2'b10);
    chk("b2b_d1", rdata_o, 32'h02020202);
    next_cycle(); idle(); settle();
    chk("b2b_v2", rvalid_o, 2'b01);
    chk("b2b_d2", rdata_o, 32'h03030303);
    next_cycle(); settle();
    chk("b2b_end_rvalid", rvalid_o, 2'b00);
    chk("b2b_end_rdata",  rdata_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
